// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: turns timer out_int rising edges into sticky pending bits, masks them,
// and presents one request at a time to a handler over an irq_req/irq_ack handshake.
// Ports: clk, rst (sync, active-high), irq_in, mask_wr, mask_din, irq_ack ->
//        irq_req, irq_id, pend, mask, ovf_cnt (saturating overrun count).
// Option: define TIMER_IRQ_ROUND_ROBIN_EN for round-robin arbitration (default: lowest index wins).
module timer_irq_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2,
    parameter int OVF_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               mask_wr,
    input  logic [NUM_SRC-1:0] mask_din,
    input  logic               irq_ack,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] pend,
    output logic [NUM_SRC-1:0] mask,
    output logic [OVF_W-1:0]   ovf_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t             state;
    state_t             state_n;
    logic [NUM_SRC-1:0] prev;
    logic [NUM_SRC-1:0] edges;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] elig;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    id_n;
    logic [ID_W-1:0]    sel;
    logic               found;
    logic               ack_hit;
    logic               ovr;

    assign edges   = irq_in & ~prev;
    assign ack_hit = (state == REQ) && irq_ack;
    assign clr     = ack_hit ? (NUM_SRC'(1) << id_q) : '0;
    // A new edge on a bit being acked this cycle re-arms it instead of overrunning.
    assign ovr     = |(edges & pend & ~clr);
    assign elig    = pend & ~mask;
    assign irq_req = (state == REQ);
    assign irq_id  = id_q;

`ifdef TIMER_IRQ_ROUND_ROBIN_EN
    logic [ID_W-1:0] last;

    // Search begins one past the last granted source and wraps.
    always_comb begin
        int idx;
        idx   = 0;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(last) + 1 + k) % NUM_SRC;
            if (!found && elig[idx]) begin
                sel   = ID_W'(idx);
                found = 1'b1;
            end
        end
    end

    // Reset value NUM_SRC-1 makes source 0 the first candidate.
    always_ff @(posedge clk) begin
        if (rst)
            last <= ID_W'(NUM_SRC - 1);
        else if (ack_hit)
            last <= id_q;
    end
`else
    // Scan downward so the lowest eligible index is the last one written.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel   = ID_W'(i);
                found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_n = state;
        id_n    = id_q;
        case (state)
            IDLE: begin
                if (found) begin
                    id_n    = sel;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (irq_ack)
                    state_n = GAP;
            end
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            id_q    <= '0;
            prev    <= '0;
            pend    <= '0;
            mask    <= '0;
            ovf_cnt <= '0;
        end else begin
            state <= state_n;
            id_q  <= id_n;
            prev  <= irq_in;
            pend  <= (pend & ~clr) | edges;
            if (mask_wr)
                mask <= mask_din;
            if (ovr && (ovf_cnt != {OVF_W{1'b1}}))
                ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb_timer_irq_ctrl: self-checking bench for timer_irq_ctrl (4 sources).
// Table vectors, directed corner sequences and random stimulus against a reference model.
module tb_timer_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq_in;
    logic       mask_wr;
    logic [3:0] mask_din;
    logic       irq_ack;
    logic       irq_req;
    logic [1:0] irq_id;
    logic [3:0] pend;
    logic [3:0] mask;
    logic [3:0] ovf_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    timer_irq_ctrl #(.NUM_SRC(4), .ID_W(2), .OVF_W(4)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .mask_wr(mask_wr),
        .mask_din(mask_din), .irq_ack(irq_ack), .irq_req(irq_req),
        .irq_id(irq_id), .pend(pend), .mask(mask), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = idle, 1 = request outstanding, 2 = gap.
    bit [3:0] m_prev, m_pend, m_mask;
    int       m_ovf, m_phase, m_id, m_last;

    task automatic model_reset();
        m_prev = 0; m_pend = 0; m_mask = 0;
        m_ovf = 0; m_phase = 0; m_id = 0; m_last = 3;
    endtask

    task automatic model(input bit r, input bit [3:0] in, input bit wr,
                         input bit [3:0] din, input bit ack);
        bit [3:0] e, c, el;
        bit       lost;
        int       nid;
        if (r) begin
            model_reset();
            return;
        end
        e = in & ~m_prev;
        c = 0;
        if (m_phase == 1 && ack) c[m_id] = 1'b1;
        lost = 0;
        for (int i = 0; i < 4; i++)
            if (e[i] && m_pend[i] && !c[i]) lost = 1;
        if (lost && m_ovf < 15) m_ovf++;
        el  = m_pend & ~m_mask;
        nid = -1;
        for (int k = 0; k < 4; k++) begin
            int idx;
`ifdef TIMER_IRQ_ROUND_ROBIN_EN
            idx = (m_last + 1 + k) % 4;
`else
            idx = k;
`endif
            if (nid < 0 && el[idx]) nid = idx;
        end
        if (m_phase == 0) begin
            if (nid >= 0) begin m_id = nid; m_phase = 1; end
        end else if (m_phase == 1) begin
            if (ack) begin m_last = m_id; m_phase = 2; end
        end else begin
            m_phase = 0;
        end
        m_pend = (m_pend & ~c) | e;
        if (wr) m_mask = din;
        m_prev = in;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit [3:0] in, input bit wr,
                        input bit [3:0] din, input bit ack);
        logic [14:0] exp;
        rst = r; irq_in = in; mask_wr = wr; mask_din = din; irq_ack = ack;
        @(posedge clk);
        model(r, in, wr, din, ack);
        #1;
        exp = {(m_phase == 1), 2'(m_id), m_pend, m_mask, 4'(m_ovf)};
        chk("model", {17'd0, irq_req, irq_id, pend, mask, ovf_cnt}, {17'd0, exp});
    endtask

    typedef struct {
        bit       r;
        bit [3:0] in;
        bit       ack;
        bit       ereq;
        bit [1:0] eid;
        bit [3:0] epend;
    } vec_t;

    vec_t tbl[$];

    initial begin
        model_reset();
        // Scenario 1: single source, ack, gap; Scenario 2: two sources in one cycle.
        tbl = '{
            '{1, 4'h0, 0, 0, 2'd0, 4'h0},
            '{0, 4'h4, 0, 0, 2'd0, 4'h4},
            '{0, 4'h4, 0, 1, 2'd2, 4'h4},
            '{0, 4'h4, 0, 1, 2'd2, 4'h4},
            '{0, 4'h0, 1, 0, 2'd2, 4'h0},
            '{0, 4'h0, 0, 0, 2'd2, 4'h0},
            '{1, 4'h0, 0, 0, 2'd0, 4'h0},
            '{0, 4'ha, 0, 0, 2'd0, 4'ha},
            '{0, 4'ha, 0, 1, 2'd1, 4'ha},
            '{0, 4'h0, 1, 0, 2'd1, 4'h8},
            '{0, 4'h0, 0, 0, 2'd1, 4'h8},
            '{0, 4'h0, 0, 1, 2'd3, 4'h8},
            '{0, 4'h0, 1, 0, 2'd3, 4'h0},
            '{0, 4'h0, 0, 0, 2'd3, 4'h0}
        };
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].in, 0, 0, tbl[i].ack);
            chk($sformatf("tbl%0d_req", i), 32'(irq_req), 32'(tbl[i].ereq));
            chk($sformatf("tbl%0d_pend", i), 32'(pend), 32'(tbl[i].epend));
            if (tbl[i].ereq)
                chk($sformatf("tbl%0d_id", i), 32'(irq_id), 32'(tbl[i].eid));
        end

        // Masked source pends but does not request until unmasked.
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 4'h1, 0);
        chk("mask_wr", 32'(mask), 32'h1);
        step(0, 4'h1, 0, 0, 0);
        chk("mask_pend", 32'(pend), 32'h1);
        step(0, 4'h1, 0, 0, 0);
        chk("mask_noreq", 32'(irq_req), 32'h0);
        step(0, 4'h1, 1, 4'h0, 0);
        chk("mask_still0", 32'(irq_req), 32'h0);
        step(0, 4'h1, 0, 0, 0);
        chk("unmask_req", 32'(irq_req), 32'h1);
        chk("unmask_id", 32'(irq_id), 32'h0);

        // Overrun saturation: 17 pulses, no ack.
        step(1, 0, 0, 0, 0);
        for (int p = 0; p < 17; p++) begin
            step(0, 4'h1, 0, 0, 0);
            step(0, 4'h0, 0, 0, 0);
        end
        chk("ovf_sat", 32'(ovf_cnt), 32'd15);
        chk("ovf_pend", 32'(pend), 32'h1);
        chk("ovf_req", 32'(irq_req), 32'h1);
        chk("ovf_id", 32'(irq_id), 32'h0);

        // Active id frozen while a lower-index source arrives.
        step(1, 0, 0, 0, 0);
        step(0, 4'h4, 0, 0, 0);
        step(0, 4'h4, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            step(0, 4'h5, 0, 0, 0);
            chk("hold_id", 32'(irq_id), 32'd2);
        end
        step(0, 4'h5, 1, 0, 1);
        chk("hold_gap", 32'(irq_req), 32'h0);
        step(0, 4'h5, 0, 0, 0);
        step(0, 4'h5, 0, 0, 0);
        chk("next_req", 32'(irq_req), 32'h1);
        chk("next_id", 32'(irq_id), 32'd0);

        // Same-cycle set and ack-clear: set wins, no overrun.
        step(1, 0, 0, 0, 0);
        step(0, 4'h2, 0, 0, 0);
        step(0, 4'h0, 0, 0, 0);
        step(0, 4'h2, 0, 0, 1);
        chk("setwin_pend", 32'(pend), 32'h2);
        chk("setwin_ovf", 32'(ovf_cnt), 32'd0);

        // Reset mid-handshake.
        step(1, 0, 0, 0, 0);
        step(0, 4'h6, 1, 4'h8, 0);
        step(0, 4'h6, 0, 0, 0);
        step(0, 4'h0, 0, 0, 0);
        step(0, 4'h6, 0, 0, 0);
        chk("pre_rst_pend", 32'(pend), 32'h6);
        step(1, 4'h6, 0, 0, 0);
        chk("rst_req", 32'(irq_req), 32'h0);
        chk("rst_pend", 32'(pend), 32'h0);
        chk("rst_ovf", 32'(ovf_cnt), 32'h0);
        chk("rst_mask", 32'(mask), 32'h0);

        // Random traffic against the model.
        for (int t = 0; t < 800; t++) begin
            step($urandom_range(0, 99) == 0, 4'($urandom),
                 $urandom_range(0, 15) == 0, 4'($urandom),
                 $urandom_range(0, 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
